cache_plru_array: RTL



---
 rtl/cache_plru_array.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cache_plru_array.sv
`default_nettype none
// ============================================================================
// Module   : cache_plru_array
// Purpose  : Per-set 7-bit tree pseudo-LRU store for an 8-way cache. Applies
//            the tree update on every hit/fill and answers victim queries,
//            preferring invalid ways over the PLRU choice.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            flush           - pulse; re-initialises every tree (sweep)
//            ready           - high when accesses/queries are accepted
//            acc_valid/set/way - hit or fill that updates a tree
//            vic_req/set/inv - victim query with per-way invalid mask
//            vic_valid/way   - registered victim result (one-cycle pulse)
//            plru_out        - tree bits the victim was derived from
// Revision : 1.0 - initial release
// ============================================================================
module cache_plru_array #(
  parameter int SETS     = 64,
  parameter int SET_BITS = 6,
  parameter int WAYS     = 8,
  parameter int WAYS_REP = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic                ready,
  input  logic                acc_valid,
  input  logic [SET_BITS-1:0] acc_set,
  input  logic [WAYS_REP-1:0] acc_way,
  input  logic                vic_req,
  input  logic [SET_BITS-1:0] vic_set,
  input  logic [WAYS-1:0]     vic_inv,
  output logic                vic_valid,
  output logic [WAYS_REP-1:0] vic_way,
  output logic [WAYS-2:0]     plru_out
);

  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic [SET_BITS-1:0]   idx_q;
  logic                  ready_q;
  logic                  vic_valid_q;
  logic [WAYS_REP-1:0]   vic_way_q;
  logic [WAYS-2:0]       plru_out_q;
  logic [WAYS-2:0]       mem_q [SETS];

  logic [WAYS-2:0]       acc_tree_d;
  logic [WAYS-2:0]       vic_tree_d;
  logic [WAYS_REP-1:0]   vic_way_d;
  logic                  acc_we;

  // Set the three bits on the path to way w toward w; leaf index is
  // 3 + 2*w[2] + w[1].
  function automatic logic [WAYS-2:0] tree_update(input logic [WAYS-2:0] p,
                                                  input logic [WAYS_REP-1:0] w);
    logic [WAYS-2:0] n;
    logic [2:0]      leaf;
    n    = p;
    leaf = 3'd3 + {1'b0, w[2:1]};
    n[0] = w[2];
    if (w[2]) n[2] = w[1];
    else      n[1] = w[1];
    n[leaf] = w[0];
    return n;
  endfunction

  // Lowest-index invalid way wins; otherwise walk away from the MRU side.
  function automatic logic [WAYS_REP-1:0] pick_victim(input logic [WAYS-2:0] p,
                                                      input logic [WAYS-1:0] inv);
    logic [WAYS_REP-1:0] v;
    logic [2:0]          leaf;
    v = '0;
    if (inv != '0) begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (inv[i]) v = WAYS_REP'(i);
      end
    end else begin
      v[2] = ~p[0];
      v[1] = v[2] ? ~p[2] : ~p[1];
      leaf = 3'd3 + {1'b0, v[2:1]};
      v[0] = ~p[leaf];
    end
    return v;
  endfunction

  assign acc_we     = (state_q == ST_RUN) && acc_valid && !flush;
  assign acc_tree_d = tree_update(mem_q[acc_set], acc_way);

  // Same-set access in the query cycle is forwarded so the query sees the
  // tree as it will be after this edge.
  always_comb begin
    vic_tree_d = mem_q[vic_set];
    if (acc_we && (acc_set == vic_set)) vic_tree_d = acc_tree_d;
  end

  assign vic_way_d = pick_victim(vic_tree_d, vic_inv);

  // Tree storage has no reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[idx_q] <= '0;
    end else if (acc_we) begin
      mem_q[acc_set] <= acc_tree_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      ready_q     <= 1'b0;
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
      plru_out_q  <= '0;
    end else begin
      vic_valid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (flush) begin
            idx_q <= '0;
          end else if (idx_q == LAST_SET) begin
            idx_q   <= '0;
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end else if (vic_req) begin
            vic_valid_q <= 1'b1;
            vic_way_q   <= vic_way_d;
            plru_out_q  <= vic_tree_d;
          end
        end
        default: begin
          state_q <= ST_INIT;
          idx_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign vic_valid = vic_valid_q;
  assign vic_way   = vic_way_q;
  assign plru_out  = plru_out_q;

endmodule
`default_nettype wire
